// File: rtl/cpu_datapath.sv
// Single-bus 32-bit CPU datapath: R0..R15, PC, HI/LO, Y, 64-bit Z, MAR/MDR, InPort, C and ALU.
// Optional instruction register (IRin / IR_q ports) enabled by defining DATAPATH_IR_EN.
module cpu_datapath (
  input  logic        clk,
  input  logic        clr,
  input  logic        R0in,  R1in,  R2in,  R3in,  R4in,  R5in,  R6in,  R7in,
  input  logic        R8in,  R9in,  R10in, R11in, R12in, R13in, R14in, R15in,
  input  logic        PCin,
  input  logic        HIin,
  input  logic        LOin,
  input  logic        Zin,
  input  logic        MARin,
  input  logic        MDRin,
  input  logic        InPortin,
  input  logic        Cin,
  input  logic        Yin,
  input  logic        incPC,
  input  logic        Read,
  input  logic [4:0]  opcode,
  input  logic [31:0] Mdatain,
  input  logic        R0out,  R1out,  R2out,  R3out,  R4out,  R5out,  R6out,  R7out,
  input  logic        R8out,  R9out,  R10out, R11out, R12out, R13out, R14out, R15out,
  input  logic        HIout,
  input  logic        LOout,
  input  logic        ZHighOut,
  input  logic        ZLowOut,
  input  logic        PCout,
  input  logic        MDRout,
  input  logic        InPortOut,
  input  logic        Cout,
`ifdef DATAPATH_IR_EN
  input  logic        IRin,
  output logic [31:0] IR_q,
`endif
  output logic [31:0] BusMuxOut,
  output logic [31:0] MAR_q
);

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00011,
    OP_SUB  = 5'b00100,
    OP_SHR  = 5'b00101,
    OP_SHRA = 5'b00110,
    OP_SHL  = 5'b00111,
    OP_ROR  = 5'b01000,
    OP_ROL  = 5'b01001,
    OP_AND  = 5'b01010,
    OP_OR   = 5'b01011,
    OP_MUL  = 5'b01111,
    OP_DIV  = 5'b10000,
    OP_NEG  = 5'b10001,
    OP_NOT  = 5'b10010
  } alu_op_e;

  logic [15:0] r_in_vec;
  logic [15:0] r_out_vec;

  assign r_in_vec  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                      R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};
  assign r_out_vec = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                      R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};

  logic [31:0] r_q [16];
  logic [31:0] r_d [16];
  logic [31:0] pc_q, pc_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] z_q, z_d;
  logic [31:0] mar_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] inport_q, inport_d;
  logic [31:0] c_q, c_d;
  logic [31:0] y_q, y_d;
  logic [31:0] bus;
  logic [63:0] alu_res;

  // Bus mux: sources are applied lowest-priority first so the last match wins,
  // giving R0 the highest priority and C the lowest.
  always_comb begin
    // NOTE: default assignment first so no path leaves bus unassigned (no latch).
    bus = 32'h0;
    if (Cout)      bus = c_q;
    if (InPortOut) bus = inport_q;
    if (MDRout)    bus = mdr_q;
    if (PCout)     bus = pc_q;
    if (ZLowOut)   bus = z_q[31:0];
    if (ZHighOut)  bus = z_q[63:32];
    if (LOout)     bus = lo_q;
    if (HIout)     bus = hi_q;
    for (int i = 15; i >= 0; i--) begin
      if (r_out_vec[i]) bus = r_q[i];
    end
  end

  assign BusMuxOut = bus;

  // ALU: A operand is Y, B operand is the bus.
  always_comb begin
    logic [4:0]         shamt;
    logic [63:0]        ror_w;
    logic [63:0]        rol_w;
    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic signed [63:0] prod;

    shamt   = bus[4:0];
    ror_w   = {y_q, y_q} >> shamt;
    rol_w   = {y_q, y_q} << shamt;
    a_s     = y_q;
    b_s     = bus;
    prod    = $signed({{32{y_q[31]}}, y_q}) * $signed({{32{bus[31]}}, bus});
    alu_res = 64'h0;

    if (incPC) begin
      alu_res = {32'h0, bus + 32'd1};
    end else begin
      case (opcode)
        OP_ADD:  alu_res[31:0] = y_q + bus;
        OP_SUB:  alu_res[31:0] = y_q - bus;
        OP_SHR:  alu_res[31:0] = y_q >> shamt;
        OP_SHRA: alu_res[31:0] = a_s >>> shamt;
        OP_SHL:  alu_res[31:0] = y_q << shamt;
        OP_ROR:  alu_res[31:0] = ror_w[31:0];
        OP_ROL:  alu_res[31:0] = rol_w[63:32];
        OP_AND:  alu_res[31:0] = y_q & bus;
        OP_OR:   alu_res[31:0] = y_q | bus;
        OP_MUL:  alu_res       = prod;
        OP_DIV: begin
          // Quotient in the low word, remainder (sign of A) in the high word.
          if (bus == 32'h0) begin
            alu_res = {y_q, 32'hFFFF_FFFF};
          end else begin
            alu_res = {32'(a_s % b_s), 32'(a_s / b_s)};
          end
        end
        OP_NEG:  alu_res[31:0] = 32'h0 - bus;
        OP_NOT:  alu_res[31:0] = ~bus;
        default: alu_res = 64'h0;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      r_d[i] = r_in_vec[i] ? bus : r_q[i];
    end
    pc_d     = PCin     ? bus     : pc_q;
    hi_d     = HIin     ? bus     : hi_q;
    lo_d     = LOin     ? bus     : lo_q;
    z_d      = Zin      ? alu_res : z_q;
    mar_d    = MARin    ? bus     : MAR_q;
    inport_d = InPortin ? bus     : inport_q;
    c_d      = Cin      ? bus     : c_q;
    y_d      = Yin      ? bus     : y_q;
    mdr_d    = mdr_q;
    if (MDRin) mdr_d = Read ? Mdatain : bus;
  end

  // Synchronous active-low clear overrides every load enable.
  always_ff @(posedge clk) begin
    if (!clr) begin
      // NOTE: the register file is a small flop array, so it is cleared in the
      // reset branch like the other registers rather than left uninitialised.
      for (int i = 0; i < 16; i++) begin
        r_q[i] <= 32'h0;
      end
      pc_q     <= 32'h0;
      hi_q     <= 32'h0;
      lo_q     <= 32'h0;
      z_q      <= 64'h0;
      MAR_q    <= 32'h0;
      mdr_q    <= 32'h0;
      inport_q <= 32'h0;
      c_q      <= 32'h0;
      y_q      <= 32'h0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      for (int i = 0; i < 16; i++) begin
        r_q[i] <= r_d[i];
      end
      pc_q     <= pc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      z_q      <= z_d;
      MAR_q    <= mar_d;
      mdr_q    <= mdr_d;
      inport_q <= inport_d;
      c_q      <= c_d;
      y_q      <= y_d;
    end
  end

`ifdef DATAPATH_IR_EN
  logic [31:0] ir_d;

  always_comb begin
    ir_d = IRin ? bus : IR_q;
  end

  always_ff @(posedge clk) begin
    if (!clr) IR_q <= 32'h0;
    else      IR_q <= ir_d;
  end
`endif

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed self-checking bench for cpu_datapath: reset, register moves, PC increment,
// ALU operations including DIV/MUL edge cases, and bus priority.
module tb_cpu_datapath;

  logic        clk = 1'b0;
  logic        clr;
  logic [15:0] r_in, r_out;
  logic        PCin, HIin, LOin, Zin, MARin, MDRin, InPortin, Cin, Yin;
  logic        incPC, Read;
  logic [4:0]  opcode;
  logic [31:0] Mdatain;
  logic        HIout, LOout, ZHighOut, ZLowOut, PCout, MDRout, InPortOut, Cout;
  logic [31:0] BusMuxOut, MAR_q;
`ifdef DATAPATH_IR_EN
  logic        IRin;
  logic [31:0] IR_q;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_datapath dut (
    .clk(clk), .clr(clr),
    .R0in(r_in[0]),   .R1in(r_in[1]),   .R2in(r_in[2]),   .R3in(r_in[3]),
    .R4in(r_in[4]),   .R5in(r_in[5]),   .R6in(r_in[6]),   .R7in(r_in[7]),
    .R8in(r_in[8]),   .R9in(r_in[9]),   .R10in(r_in[10]), .R11in(r_in[11]),
    .R12in(r_in[12]), .R13in(r_in[13]), .R14in(r_in[14]), .R15in(r_in[15]),
    .PCin(PCin), .HIin(HIin), .LOin(LOin), .Zin(Zin), .MARin(MARin), .MDRin(MDRin),
    .InPortin(InPortin), .Cin(Cin), .Yin(Yin),
    .incPC(incPC), .Read(Read), .opcode(opcode), .Mdatain(Mdatain),
    .R0out(r_out[0]),   .R1out(r_out[1]),   .R2out(r_out[2]),   .R3out(r_out[3]),
    .R4out(r_out[4]),   .R5out(r_out[5]),   .R6out(r_out[6]),   .R7out(r_out[7]),
    .R8out(r_out[8]),   .R9out(r_out[9]),   .R10out(r_out[10]), .R11out(r_out[11]),
    .R12out(r_out[12]), .R13out(r_out[13]), .R14out(r_out[14]), .R15out(r_out[15]),
    .HIout(HIout), .LOout(LOout), .ZHighOut(ZHighOut), .ZLowOut(ZLowOut),
    .PCout(PCout), .MDRout(MDRout), .InPortOut(InPortOut), .Cout(Cout),
`ifdef DATAPATH_IR_EN
    .IRin(IRin), .IR_q(IR_q),
`endif
    .BusMuxOut(BusMuxOut), .MAR_q(MAR_q)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic idle();
    clr = 1'b1; r_in = '0; r_out = '0;
    PCin = 0; HIin = 0; LOin = 0; Zin = 0; MARin = 0; MDRin = 0; InPortin = 0; Cin = 0; Yin = 0;
    incPC = 0; Read = 0; opcode = '0; Mdatain = '0;
    HIout = 0; LOout = 0; ZHighOut = 0; ZLowOut = 0; PCout = 0; MDRout = 0; InPortOut = 0; Cout = 0;
`ifdef DATAPATH_IR_EN
    IRin = 0;
`endif
  endtask

  // One rising edge with the currently driven controls, then return to idle.
  task automatic cycle();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  // Source index: 0..15 = R0..R15, 16 HI, 17 LO, 18 ZHigh, 19 ZLow, 20 PC, 21 MDR, 22 InPort, 23 C.
  task automatic drive_out(input int k);
    if (k < 16) r_out[k] = 1'b1;
    else begin
      case (k)
        16: HIout = 1; 17: LOout = 1; 18: ZHighOut = 1; 19: ZLowOut = 1;
        20: PCout = 1; 21: MDRout = 1; 22: InPortOut = 1; default: Cout = 1;
      endcase
    end
  endtask

  task automatic obs(input string tag, input int k, input logic [31:0] expected);
    drive_out(k);
    #1;
    check(tag, {32'h0, BusMuxOut}, {32'h0, expected});
    idle();
    #1;
  endtask

  task automatic load_mdr(input logic [31:0] val);
    Mdatain = val; Read = 1; MDRin = 1;
    cycle();
  endtask

  task automatic alu_run(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
    load_mdr(a);
    MDRout = 1; Yin = 1;
    cycle();
    load_mdr(b);
    MDRout = 1; opcode = op; Zin = 1;
    cycle();
  endtask

  task automatic alu_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] op, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    alu_run(a, b, op);
    obs({tag, "_lo"}, 19, exp_lo);
    obs({tag, "_hi"}, 18, exp_hi);
  endtask

  initial begin
    idle();
    clr = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    idle();

    // Fill every register with a non-zero value, then clear with loads still asserted.
    load_mdr(32'hDEAD_BEEF);
    MDRout = 1; r_in = '1; PCin = 1; HIin = 1; LOin = 1; MARin = 1; InPortin = 1; Cin = 1; Yin = 1;
    cycle();
    check("pre_mar", {32'h0, MAR_q}, 64'hDEAD_BEEF);
    obs("pre_r7", 7, 32'hDEAD_BEEF);
    MDRout = 1; opcode = 5'b00011; Zin = 1;
    cycle();
    obs("pre_zlo", 19, 32'hBD5B_7DDE);
    obs("pre_zhi", 18, 32'h0);

    clr = 0; MDRout = 1; r_in = '1; PCin = 1; HIin = 1; LOin = 1; MARin = 1; InPortin = 1;
    Cin = 1; Yin = 1; Zin = 1; opcode = 5'b00011; Mdatain = 32'h1234; Read = 1; MDRin = 1;
    cycle();
    check("rst_mar", {32'h0, MAR_q}, 64'h0);
    for (int k = 0; k < 24; k++) begin
      obs($sformatf("rst_src%0d", k), k, 32'h0);
    end
    alu_check("rst_y", 32'h5, 32'h5, 5'b00011, 32'h0000_000A, 32'h0);
    // Y was just reloaded; confirm a cleared Y would add as zero by clearing again.
    clr = 0;
    cycle();
    load_mdr(32'h5);
    MDRout = 1; opcode = 5'b00011; Zin = 1;
    cycle();
    obs("rst_y_zero", 19, 32'h5);

    // R2=111, R3=35, R1 = R2 AND R3.
    load_mdr(32'd111); MDRout = 1; r_in[2] = 1; cycle();
    load_mdr(32'd35);  MDRout = 1; r_in[3] = 1; cycle();
    r_out[2] = 1; Yin = 1; cycle();
    r_out[3] = 1; opcode = 5'b01010; Zin = 1; cycle();
    ZLowOut = 1; r_in[1] = 1; cycle();
    obs("and_r1", 1, 32'd35);

    // PC increment from 0.
    PCout = 1; MARin = 1; incPC = 1; Zin = 1; cycle();
    check("pc_mar", {32'h0, MAR_q}, 64'h0);
    obs("pc_zlo", 19, 32'h1);
    ZLowOut = 1; PCin = 1; cycle();
    obs("pc_one", 20, 32'h1);

    // PC wrap, incPC overriding an otherwise valid opcode.
    load_mdr(32'hFFFF_FFFF); MDRout = 1; PCin = 1; cycle();
    PCout = 1; incPC = 1; opcode = 5'b01111; Zin = 1; cycle();
    obs("pc_wrap_lo", 19, 32'h0);
    obs("pc_wrap_hi", 18, 32'h0);

    // ALU operations.
    alu_check("div_neg",  32'd16,        32'hFFFF_FFFE, 5'b10000, 32'hFFFF_FFF8, 32'h0);
    alu_check("div_pos",  32'd17,        32'd5,         5'b10000, 32'd3,         32'd2);
    alu_check("div_nega", 32'hFFFF_FFEF, 32'd5,         5'b10000, 32'hFFFF_FFFD, 32'hFFFF_FFFE);
    alu_check("div_zero", 32'd7,         32'd0,         5'b10000, 32'hFFFF_FFFF, 32'd7);
    alu_check("mul",      32'h8000_0000, 32'd2,         5'b01111, 32'h0,         32'hFFFF_FFFF);
    alu_check("mul_pos",  32'h0001_0000, 32'h0001_0000, 5'b01111, 32'h0,         32'h1);
    alu_check("shra",     32'h8000_0000, 32'd4,         5'b00110, 32'hF800_0000, 32'h0);
    alu_check("shr",      32'h8000_0000, 32'd4,         5'b00101, 32'h0800_0000, 32'h0);
    alu_check("shl",      32'h1,         32'd33,        5'b00111, 32'h2,         32'h0);
    alu_check("rol",      32'h8000_0000, 32'd1,         5'b01001, 32'h1,         32'h0);
    alu_check("ror",      32'h0000_0001, 32'd1,         5'b01000, 32'h8000_0000, 32'h0);
    alu_check("ror_zero", 32'h1234_5678, 32'd0,         5'b01000, 32'h1234_5678, 32'h0);
    alu_check("add_wrap", 32'hFFFF_FFFF, 32'd1,         5'b00011, 32'h0,         32'h0);
    alu_check("sub",      32'd3,         32'd5,         5'b00100, 32'hFFFF_FFFE, 32'h0);
    alu_check("or",       32'hF0F0_0000, 32'h0000_0F0F, 5'b01011, 32'hF0F0_0F0F, 32'h0);
    alu_check("neg",      32'd9,         32'd5,         5'b10001, 32'hFFFF_FFFB, 32'h0);
    alu_check("not",      32'd9,         32'h0,         5'b10010, 32'hFFFF_FFFF, 32'h0);
    alu_check("illegal",  32'd9,         32'd9,         5'b00000, 32'h0,         32'h0);

    // Bus priority and MDR-from-bus path.
    load_mdr(32'h55); MDRout = 1; r_in[5] = 1; cycle();
    load_mdr(32'hAA);
    MDRout = 1; r_out[5] = 1; #1;
    check("prio_r5_mdr", {32'h0, BusMuxOut}, 64'h55);
    idle(); #1;
    load_mdr(32'h11); MDRout = 1; HIin = 1; cycle();
    load_mdr(32'h22); MDRout = 1; LOin = 1; InPortin = 1; Cin = 1; cycle();
    HIout = 1; LOout = 1; #1;
    check("prio_hi_lo", {32'h0, BusMuxOut}, 64'h11);
    idle(); #1;
    InPortOut = 1; Cout = 1; #1;
    check("prio_in_c", {32'h0, BusMuxOut}, 64'h22);
    idle(); #1;
    check("bus_none", {32'h0, BusMuxOut}, 64'h0);
    r_out[5] = 1; MDRin = 1; Read = 0; Mdatain = 32'h9999; cycle();
    obs("mdr_from_bus", 21, 32'h55);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
